// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width,
// bubble instruction word and fetch FSM state encoding.
package riscv_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_t;

  function automatic logic [XLEN-1:0] pc_plus_4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/riscv_fetch_register.sv
// IF/ID pipeline register: synchronous active-low reset, clear (flush)
// beats enable (not stalled); an enabled cycle without a load becomes a bubble.
module riscv_fetch_register
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic            clr,
  input  logic            load,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_4d,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      instr      <= NOP_INSTR;
      pc         <= '0;
      pc_plus_4d <= '0;
      valid      <= 1'b0;
    end else if (en) begin
      if (load) begin
        instr      <= load_instr;
        pc         <= load_pc;
        pc_plus_4d <= pc_plus_4(load_pc);
        valid      <= 1'b1;
      end else begin
        // Bubble keeps the old PC fields; only the instruction and valid change.
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/riscv_fetch.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem request FSM,
// one-entry holding buffer for stalled responses, and the IF/ID register.
module riscv_fetch
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_stall_d,
  input  logic            i_flush_d,
  input  logic            i_pc_src_e,
  input  logic [XLEN-1:0] i_pc_target_e,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_instr_d,
  output logic [XLEN-1:0] o_pc_d,
  output logic [XLEN-1:0] o_pc_plus_4d,
  output logic            o_valid_d
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc_f, pc_f_next;
  logic [XLEN-1:0] pc_req, pc_req_next;
  logic [XLEN-1:0] hold_instr, hold_instr_next;
  logic [XLEN-1:0] hold_pc, hold_pc_next;
  logic            deliver;
  logic [XLEN-1:0] deliver_instr;
  logic [XLEN-1:0] deliver_pc;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state      <= ST_REQ;
      pc_f       <= RESET_PC;
      pc_req     <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      state      <= state_next;
      pc_f       <= pc_f_next;
      pc_req     <= pc_req_next;
      hold_instr <= hold_instr_next;
      hold_pc    <= hold_pc_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_f_next       = pc_f;
    pc_req_next     = pc_req;
    hold_instr_next = hold_instr;
    hold_pc_next    = hold_pc;
    o_imem_req      = 1'b0;
    deliver         = 1'b0;
    deliver_instr   = hold_instr;
    deliver_pc      = hold_pc;

    case (state)
      ST_REQ: begin
        o_imem_req = i_rstn && !i_stall_d && !i_pc_src_e;
        if (i_pc_src_e) begin
          pc_f_next = i_pc_target_e;
        end else if (o_imem_req && i_imem_gnt) begin
          pc_req_next = pc_f;
          pc_f_next   = pc_plus_4(pc_f);
          state_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A redirect before the response arrives leaves it in flight; DROP eats it.
        if (i_pc_src_e) begin
          pc_f_next  = i_pc_target_e;
          state_next = i_imem_rvalid ? ST_REQ : ST_DROP;
        end else if (i_imem_rvalid) begin
          if (i_stall_d) begin
            hold_instr_next = i_imem_rdata;
            hold_pc_next    = pc_req;
            state_next      = ST_HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = i_imem_rdata;
            deliver_pc    = pc_req;
            state_next    = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (i_pc_src_e) begin
          pc_f_next  = i_pc_target_e;
          state_next = ST_REQ;
        end else if (!i_stall_d) begin
          deliver    = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_DROP: begin
        if (i_pc_src_e) begin
          pc_f_next = i_pc_target_e;
        end
        if (i_imem_rvalid) begin
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_REQ;
    endcase
  end

  assign o_imem_addr = pc_f;

  riscv_fetch_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (i_clk),
    .rstn       (i_rstn),
    .en         (!i_stall_d),
    .clr        (i_flush_d),
    .load       (deliver),
    .load_instr (deliver_instr),
    .load_pc    (deliver_pc),
    .instr      (o_instr_d),
    .pc         (o_pc_d),
    .pc_plus_4d (o_pc_plus_4d),
    .valid      (o_valid_d)
  );

endmodule

// File: tb/tb_riscv_fetch.sv
// Randomized bench for riscv_fetch: a behavioural memory plus a transaction-level
// model of the fetch stage predict imem requests and IF/ID contents every cycle.
module tb_riscv_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          CYCLES    = 4000;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_stall_d;
  logic        i_flush_d;
  logic        i_pc_src_e;
  logic [31:0] i_pc_target_e;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr_d;
  logic [31:0] o_pc_d;
  logic [31:0] o_pc_plus_4d;
  logic        o_valid_d;

  riscv_fetch #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_stall_d     (i_stall_d),
    .i_flush_d     (i_flush_d),
    .i_pc_src_e    (i_pc_src_e),
    .i_pc_target_e (i_pc_target_e),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr_d     (o_instr_d),
    .o_pc_d        (o_pc_d),
    .o_pc_plus_4d  (o_pc_plus_4d),
    .o_valid_d     (o_valid_d)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Model of the fetch stage in transaction terms: what is owed by memory,
  // whether that answer is still wanted, and what is parked waiting for decode.
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  logic        m_busy;
  logic        m_discard;
  logic        m_buf_valid;
  logic [31:0] m_buf_instr;
  logic [31:0] m_buf_pc;
  logic [31:0] e_instr;
  logic [31:0] e_pc;
  logic [31:0] e_pc4;
  logic        e_valid;
  logic        exp_req;
  logic        mem_pending;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus();
    i_rstn        = ($urandom_range(0, 99) >= 2);
    i_stall_d     = ($urandom_range(0, 99) < 25);
    i_flush_d     = ($urandom_range(0, 99) < 10);
    i_pc_src_e    = ($urandom_range(0, 99) < 12);
    i_pc_target_e = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
    i_imem_gnt    = ($urandom_range(0, 9) < 7);
    i_imem_rvalid = mem_pending && i_rstn && ($urandom_range(0, 1) == 1);
    i_imem_rdata  = $urandom;
  endtask

  task automatic model_step();
    logic        got;
    logic [31:0] gi;
    logic [31:0] gp;
    logic        accept;
    got    = 1'b0;
    gi     = '0;
    gp     = '0;
    accept = exp_req && i_imem_gnt;

    if (!i_rstn) begin
      m_pc        = RESET_PC;
      m_busy      = 1'b0;
      m_discard   = 1'b0;
      m_buf_valid = 1'b0;
      e_instr     = NOP_INSTR;
      e_pc        = '0;
      e_pc4       = '0;
      e_valid     = 1'b0;
      mem_pending = 1'b0;
      return;
    end

    if (mem_pending && i_imem_rvalid) mem_pending = 1'b0;
    else if (accept) mem_pending = 1'b1;

    if (m_discard) begin
      if (i_imem_rvalid) m_discard = 1'b0;
      if (i_pc_src_e) m_pc = i_pc_target_e;
    end else if (m_busy) begin
      if (i_pc_src_e) begin
        m_pc      = i_pc_target_e;
        m_busy    = 1'b0;
        m_discard = !i_imem_rvalid;
      end else if (i_imem_rvalid) begin
        m_busy = 1'b0;
        if (i_stall_d) begin
          m_buf_valid = 1'b1;
          m_buf_instr = i_imem_rdata;
          m_buf_pc    = m_req_pc;
        end else begin
          got = 1'b1;
          gi  = i_imem_rdata;
          gp  = m_req_pc;
        end
      end
    end else if (m_buf_valid) begin
      if (i_pc_src_e) begin
        m_pc        = i_pc_target_e;
        m_buf_valid = 1'b0;
      end else if (!i_stall_d) begin
        got         = 1'b1;
        gi          = m_buf_instr;
        gp          = m_buf_pc;
        m_buf_valid = 1'b0;
      end
    end else begin
      if (i_pc_src_e) m_pc = i_pc_target_e;
      else if (accept) begin
        m_busy   = 1'b1;
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end

    if (i_flush_d) begin
      e_instr = NOP_INSTR;
      e_pc    = '0;
      e_pc4   = '0;
      e_valid = 1'b0;
    end else if (!i_stall_d) begin
      if (got) begin
        e_instr = gi;
        e_pc    = gp;
        e_pc4   = gp + 32'd4;
        e_valid = 1'b1;
      end else begin
        e_instr = NOP_INSTR;
        e_valid = 1'b0;
      end
    end
  endtask

  initial begin
    mem_pending   = 1'b0;
    i_rstn        = 1'b0;
    i_stall_d     = 1'b0;
    i_flush_d     = 1'b0;
    i_pc_src_e    = 1'b0;
    i_pc_target_e = '0;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;

    @(negedge i_clk);
    check_output("req_in_reset", {31'd0, o_imem_req}, 32'd0);
    exp_req = 1'b0;
    model_step();
    @(posedge i_clk);
    #1;
    check_output("reset_instr", o_instr_d, NOP_INSTR);
    check_output("reset_valid", {31'd0, o_valid_d}, 32'd0);

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      check_output("instr_d", o_instr_d, e_instr);
      check_output("pc_d", o_pc_d, e_pc);
      check_output("pc_plus_4d", o_pc_plus_4d, e_pc4);
      check_output("valid_d", {31'd0, o_valid_d}, {31'd0, e_valid});

      // Quiet stretch after a few thousand cycles so long in-order fetch runs occur.
      apply_stimulus();
      if (cyc > 3000 && cyc < 3200) begin
        i_rstn     = 1'b1;
        i_flush_d  = 1'b0;
        i_pc_src_e = (cyc == 3001);
        i_pc_target_e = 32'hFFFF_FFF0;
      end

      @(negedge i_clk);
      exp_req = i_rstn && !m_busy && !m_discard && !m_buf_valid && !i_stall_d && !i_pc_src_e;
      check_output("imem_req", {31'd0, o_imem_req}, {31'd0, exp_req});
      check_output("imem_addr", o_imem_addr, m_pc);
      model_step();
      @(posedge i_clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
